skid_rr_arbiter: RTL
====================

Name: skid_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready channel among NREQ upstream requesters.
- Placed directly in front of my_skid_top so several producers can feed a single skid-buffered path.
- Packet-aware: once a requester wins, it keeps the grant until a beat with last=1 transfers.
- Output is registered, giving one cycle of latency at one beat per cycle throughput.

Parameters:
DW, 8, data width per beat
NREQ, 4, number of requesters (2..16)
IW, 2, width of requester index; must satisfy 2**IW >= NREQ

Ports:
i_clk  input  1  clock; all logic on the rising edge
i_reset  input  1  synchronous, active-high reset
up_val  input  NREQ  per-requester beat valid; bit k belongs to requester k
up_bus  input  NREQ*DW  per-requester data; requester k on bits [k*DW +: DW]
up_last  input  NREQ  per-requester end-of-packet flag, qualified by up_val
up_rdy  output  NREQ  per-requester ready; combinational; at most one bit high
dn_val  output  1  registered downstream valid
dn_bus  output  DW  registered downstream data
dn_id  output  IW  index of the requester that sourced the current dn beat
dn_last  output  1  registered end-of-packet flag
dn_rdy  input  1  downstream ready (connects to up_rdy of my_skid_top)

Behaviour:
- Reset (synchronous, active-high):
  - dn_val=0, dn_bus=0, dn_id=0, dn_last=0.
  - Round-robin pointer ptr=0, state IDLE.
  - up_rdy is all-zero while i_reset=1.
- Load enable: ld = ~dn_val | dn_rdy. The output register may take a new beat only when ld=1.
- Grant selection, combinational:
  - In IDLE, g is the first k with up_val[k]=1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - In LOCKED, g = lock_id. No other requester is considered.
- up_rdy[g] = ld & up_val[g] & ~i_reset. All other up_rdy bits are 0.
- Transfer: a beat transfers when up_val[g] & up_rdy[g]. On that clock edge:
  - dn_val<=1, dn_bus<=up_bus[g], dn_id<=g, dn_last<=up_last[g].
- When ld=1 and no beat transfers, dn_val<=0. dn_bus, dn_id and dn_last keep their old values.
- When dn_val=1 and dn_rdy=0, all dn_* outputs hold stable and all up_rdy bits are 0.
- State machine:
  - IDLE: a transfer with last=0 goes to LOCKED with lock_id<=g. A transfer with last=1 stays in IDLE with ptr<=(g+1) mod NREQ.
  - LOCKED: a transfer with last=1 goes to IDLE with ptr<=(lock_id+1) mod NREQ. A transfer with last=0 stays in LOCKED.
  - LOCKED with up_val[lock_id]=0: stall. No grant goes to anyone else and the state is unchanged.
- ptr changes only on packet completion. It wraps from NREQ-1 to 0, and NREQ need not be a power of 2.
- Latency: an upstream beat appears on dn_* one cycle after its transfer edge. Back-to-back beats are sustained while dn_rdy=1.
- Single-beat packets (last=1 on the first beat) rotate fairness every beat.
- Reset mid-packet drops the lock. The first grant after reset uses ptr=0.
- Requester data, last and valid are don't-care when that requester's up_val is 0.

Test Plan:
- Reset: i_reset=1 for 8 cycles with all up_val=1 -> dn_val=0, dn_bus=0x00, dn_id=0, up_rdy=4'b0000. After release, the first grant goes to requester 0.
- Fairness: all 4 requesters valid with last=1 and dn_rdy=1, requester k sending data 0x10+k -> dn_id sequence 0,1,2,3,0,1 and dn_bus sequence 0x10,0x11,0x12,0x13,0x10,0x11, one beat per cycle, each dn beat 1 cycle after its up_rdy.
- Packet lock: requester 2 sends 3 beats (0xA0, 0xA1, 0xA2 with last on 0xA2) while requester 3 is also valid -> dn_id=2 for three consecutive beats, then dn_id=3. ptr=3 after the packet.
- Lock stall: requester 1 drops up_val for 2 cycles mid-packet while requester 0 is valid -> up_rdy=0000 and dn_val=0 during the gap, requester 0 is never granted, and requester 1 resumes afterwards.
- Backpressure: dn_rdy=0 while dn_val=1 with dn_bus=0xB3 -> dn_bus stays 0xB3 and up_rdy=0000 until dn_rdy=1. No beat is lost or duplicated, checked against a scoreboard.
- Reset mid-packet: assert i_reset while LOCKED on requester 3 -> the next cycle gives dn_val=0 and state IDLE. After release with requesters 1 and 3 valid, requester 1 is granted first.

Source files
------------

// File: rtl/skid_rr_arbiter.sv
// skid_rr_arbiter: packet-aware round-robin arbiter that merges NREQ
// valid/ready producers onto one registered downstream channel.
// A requester that wins keeps the grant until a beat with last=1 transfers;
// the round-robin pointer advances only when a packet completes.
module skid_rr_arbiter #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      up_val,
    input  logic [NREQ*DW-1:0]   up_bus,
    input  logic [NREQ-1:0]      up_last,
    output logic [NREQ-1:0]      up_rdy,
    output logic                 dn_val,
    output logic [DW-1:0]        dn_bus,
    output logic [IW-1:0]        dn_id,
    output logic                 dn_last,
    input  logic                 dn_rdy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] lock_id, lock_id_nxt;
    logic [IW-1:0] grant;
    logic          ld;
    logic          grant_val;
    logic          grant_last;
    logic [DW-1:0] grant_bus;
    logic          xfer;

    // First requester with valid set, scanning upward from start and wrapping.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] val,
                                              input logic [IW-1:0]   start);
        logic [IW-1:0] pick;
        logic [IW-1:0] cand;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(start) + i) % NREQ);
            if (!found && val[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Successor index with wrap at NREQ-1 (NREQ need not be a power of two).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // The output register may accept a new beat when empty or being drained.
    assign ld = ~dn_val | dn_rdy;

    // Grant selection: the lock owner while a packet is open, else round-robin.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = '0;
        if (state == LOCKED) begin
            grant = lock_id;
        end else begin
            grant = rr_pick(up_val, ptr);
        end
    end

    assign grant_val  = up_val[grant];
    assign grant_last = up_last[grant];
    assign grant_bus  = up_bus[int'(grant)*DW +: DW];
    assign xfer       = ld & grant_val & ~i_reset;

    // Ready goes only to the granted requester, and only when a beat can move.
    always_comb begin
        up_rdy        = '0;
        up_rdy[grant] = xfer;
    end

    // Next-state logic: open a lock on a non-final beat, release it on last.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lock_id_nxt = lock_id;
        if (xfer) begin
            unique case (state)
                IDLE: begin
                    if (grant_last) begin
                        ptr_nxt = next_idx(grant);
                    end else begin
                        state_nxt   = LOCKED;
                        lock_id_nxt = grant;
                    end
                end
                LOCKED: begin
                    if (grant_last) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_idx(lock_id);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, pointer and lock owner registers.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            state   <= IDLE;
            ptr     <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    // Downstream output register: load on transfer, empty when drained idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dn_val  <= 1'b0;
            dn_bus  <= '0;
            dn_id   <= '0;
            dn_last <= 1'b0;
        end else if (xfer) begin
            dn_val  <= 1'b1;
            dn_bus  <= grant_bus;
            dn_id   <= grant;
            dn_last <= grant_last;
        end else if (ld) begin
            dn_val  <= 1'b0;
        end
    end

endmodule
